// File: rtl/fight_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fight_pkg
// Description : Action-state codes, default frame counts and counter width
//               for the fighter action sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package fight_pkg;

    localparam int FRAME_CNT_W = 5;

    localparam int DEF_PUNCH_FRAMES     = 6;
    localparam int DEF_KICK_FRAMES      = 8;
    localparam int DEF_BLOCK_MIN_FRAMES = 2;
    localparam int DEF_STUN_FRAMES      = 10;
    localparam int DEF_COOLDOWN_FRAMES  = 4;

    typedef enum logic [2:0] {
        ACT_IDLE     = 3'd0,
        ACT_PUNCH    = 3'd1,
        ACT_KICK     = 3'd2,
        ACT_BLOCK    = 3'd3,
        ACT_STUN     = 3'd4,
        ACT_COOLDOWN = 3'd5
    } act_t;

    typedef enum logic [1:0] {
        BUF_NONE  = 2'd0,
        BUF_PUNCH = 2'd1,
        BUF_KICK  = 2'd2
    } buf_t;

endpackage
`default_nettype wire

// File: rtl/p2_action_sequencer_press_detect.sv
`default_nettype none
// ============================================================================
// Module      : action_press_detect
// Description : Frame-tick sampled rising-edge detector for one key level.
// Revision    : 1.0  initial release
// ============================================================================
module action_press_detect (
    input  logic clk,
    input  logic Reset_n,
    input  logic frame_tick,
    input  logic key_i,
    output logic press_o
);

    logic prev_q;

    // History only advances on frame ticks, so levels between ticks are invisible.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            prev_q <= 1'b0;
        end else if (frame_tick) begin
            prev_q <= key_i;
        end
    end

    assign press_o = frame_tick & key_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/p2_action_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : p2_action_sequencer
// Description : Per-player action scheduler owning the shared motion resource.
//               Optional macro INPUT_BUFFER_EN enables a one-deep press buffer.
// Revision    : 1.0  initial release
// ============================================================================
module p2_action_sequencer
    import fight_pkg::*;
#(
    parameter int PUNCH_FRAMES     = DEF_PUNCH_FRAMES,
    parameter int KICK_FRAMES      = DEF_KICK_FRAMES,
    parameter int BLOCK_MIN_FRAMES = DEF_BLOCK_MIN_FRAMES,
    parameter int STUN_FRAMES      = DEF_STUN_FRAMES,
    parameter int COOLDOWN_FRAMES  = DEF_COOLDOWN_FRAMES
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    input  logic                   frame_tick,
    input  logic                   punch_req,
    input  logic                   kick_req,
    input  logic                   block_req,
    input  logic                   hit_in,
    output logic                   punch_start,
    output logic                   kick_start,
    output logic                   block_start,
    output logic                   abort,
    output logic                   hit_blocked,
    output logic                   busy,
    output logic [2:0]             act_state,
    output logic [FRAME_CNT_W-1:0] frames_left
);

    localparam int C_MAX = (1 << FRAME_CNT_W) - 1;

    generate
        if (PUNCH_FRAMES < 1 || PUNCH_FRAMES > C_MAX ||
            KICK_FRAMES < 1 || KICK_FRAMES > C_MAX ||
            BLOCK_MIN_FRAMES < 1 || BLOCK_MIN_FRAMES > C_MAX ||
            STUN_FRAMES < 1 || STUN_FRAMES > C_MAX ||
            COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > C_MAX) begin : g_bad_param
            $error("p2_action_sequencer: frame parameters must be in 1..31");
        end
    endgenerate

    localparam logic [FRAME_CNT_W-1:0] c_punch    = FRAME_CNT_W'(PUNCH_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] c_kick     = FRAME_CNT_W'(KICK_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] c_block    = FRAME_CNT_W'(BLOCK_MIN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] c_stun     = FRAME_CNT_W'(STUN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] c_cooldown = FRAME_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] c_one      = FRAME_CNT_W'(1);
    localparam logic [FRAME_CNT_W-1:0] c_zero     = '0;

    act_t                   state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hit_pend_q, hit_pend_d;
    logic                   busy_q, busy_d;
    logic                   punch_start_q, punch_start_d;
    logic                   kick_start_q, kick_start_d;
    logic                   block_start_q, block_start_d;
    logic                   abort_q, abort_d;
    logic                   hit_blocked_q, hit_blocked_d;
    logic                   w_punch_press;
    logic                   w_kick_press;
    logic                   w_hit;
`ifdef INPUT_BUFFER_EN
    buf_t                   buf_q, buf_d;
`endif

    action_press_detect u_punch_det (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .key_i      (punch_req),
        .press_o    (w_punch_press)
    );

    action_press_detect u_kick_det (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .key_i      (kick_req),
        .press_o    (w_kick_press)
    );

    // A hit arriving on the tick cycle itself is evaluated on that tick.
    assign w_hit = hit_pend_q | hit_in;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hit_pend_d    = hit_pend_q | hit_in;
        punch_start_d = 1'b0;
        kick_start_d  = 1'b0;
        block_start_d = 1'b0;
        abort_d       = 1'b0;
        hit_blocked_d = 1'b0;
`ifdef INPUT_BUFFER_EN
        buf_d         = buf_q;
`endif
        if (frame_tick) begin
            hit_pend_d = 1'b0;
            if (w_hit && state_q == ACT_BLOCK) begin
                hit_blocked_d = 1'b1;
            end else if (w_hit && state_q != ACT_STUN) begin
                abort_d = (state_q == ACT_PUNCH) || (state_q == ACT_KICK);
                state_d = ACT_STUN;
                cnt_d   = c_stun;
`ifdef INPUT_BUFFER_EN
                buf_d   = BUF_NONE;
`endif
            end else begin
`ifdef INPUT_BUFFER_EN
                if ((state_q == ACT_PUNCH || state_q == ACT_KICK ||
                     state_q == ACT_COOLDOWN) && buf_q == BUF_NONE) begin
                    if (w_punch_press) begin
                        buf_d = BUF_PUNCH;
                    end else if (w_kick_press) begin
                        buf_d = BUF_KICK;
                    end
                end
`endif
                case (state_q)
                    ACT_IDLE: begin
                        if (block_req) begin
                            state_d       = ACT_BLOCK;
                            cnt_d         = c_block;
                            block_start_d = 1'b1;
`ifdef INPUT_BUFFER_EN
                            buf_d         = BUF_NONE;
`endif
                        end else if (w_punch_press) begin
                            state_d       = ACT_PUNCH;
                            cnt_d         = c_punch;
                            punch_start_d = 1'b1;
                        end else if (w_kick_press) begin
                            state_d      = ACT_KICK;
                            cnt_d        = c_kick;
                            kick_start_d = 1'b1;
                        end
                    end
                    ACT_PUNCH, ACT_KICK: begin
                        if (cnt_q == c_one) begin
                            state_d = ACT_COOLDOWN;
                            cnt_d   = c_cooldown;
                        end else begin
                            cnt_d = cnt_q - c_one;
                        end
                    end
                    ACT_COOLDOWN: begin
                        if (cnt_q == c_one) begin
`ifdef INPUT_BUFFER_EN
                            buf_d = BUF_NONE;
                            case (buf_q)
                                BUF_PUNCH: begin
                                    state_d       = ACT_PUNCH;
                                    cnt_d         = c_punch;
                                    punch_start_d = 1'b1;
                                end
                                BUF_KICK: begin
                                    state_d      = ACT_KICK;
                                    cnt_d        = c_kick;
                                    kick_start_d = 1'b1;
                                end
                                default: begin
                                    state_d = ACT_IDLE;
                                    cnt_d   = c_zero;
                                end
                            endcase
`else
                            state_d = ACT_IDLE;
                            cnt_d   = c_zero;
`endif
                        end else begin
                            cnt_d = cnt_q - c_one;
                        end
                    end
                    ACT_STUN: begin
                        if (cnt_q == c_one) begin
                            state_d = ACT_IDLE;
                            cnt_d   = c_zero;
                        end else begin
                            cnt_d = cnt_q - c_one;
                        end
                    end
                    ACT_BLOCK: begin
                        // Counter reaches 0 once the minimum is served and stays there while held.
                        if (cnt_q <= c_one) begin
                            if (!block_req) begin
                                state_d = ACT_IDLE;
                            end
                            cnt_d = c_zero;
                        end else begin
                            cnt_d = cnt_q - c_one;
                        end
                    end
                    default: begin
                        state_d = ACT_IDLE;
                        cnt_d   = c_zero;
                    end
                endcase
            end
        end
        busy_d = (state_d != ACT_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_q       <= ACT_IDLE;
            cnt_q         <= c_zero;
            hit_pend_q    <= 1'b0;
            busy_q        <= 1'b0;
            punch_start_q <= 1'b0;
            kick_start_q  <= 1'b0;
            block_start_q <= 1'b0;
            abort_q       <= 1'b0;
            hit_blocked_q <= 1'b0;
`ifdef INPUT_BUFFER_EN
            buf_q         <= BUF_NONE;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hit_pend_q    <= hit_pend_d;
            busy_q        <= busy_d;
            punch_start_q <= punch_start_d;
            kick_start_q  <= kick_start_d;
            block_start_q <= block_start_d;
            abort_q       <= abort_d;
            hit_blocked_q <= hit_blocked_d;
`ifdef INPUT_BUFFER_EN
            buf_q         <= buf_d;
`endif
        end
    end

    assign punch_start = punch_start_q;
    assign kick_start  = kick_start_q;
    assign block_start = block_start_q;
    assign abort       = abort_q;
    assign hit_blocked = hit_blocked_q;
    assign busy        = busy_q;
    assign act_state   = state_q;
    assign frames_left = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_p2_action_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_p2_action_sequencer
// Description : Directed self-checking bench for p2_action_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_p2_action_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PUN  = 3'd1;
    localparam logic [2:0] S_KICK = 3'd2;
    localparam logic [2:0] S_BLK  = 3'd3;
    localparam logic [2:0] S_STUN = 3'd4;
    localparam logic [2:0] S_COOL = 3'd5;

    // Pulse vector order: punch_start, kick_start, block_start, abort, hit_blocked
    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_PUNCH = 5'b10000;
    localparam logic [4:0] P_KICK  = 5'b01000;
    localparam logic [4:0] P_BLOCK = 5'b00100;
    localparam logic [4:0] P_ABORT = 5'b00010;
    localparam logic [4:0] P_HB    = 5'b00001;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick;
    logic       punch_req;
    logic       kick_req;
    logic       block_req;
    logic       hit_in;
    logic       punch_start;
    logic       kick_start;
    logic       block_start;
    logic       abort;
    logic       hit_blocked;
    logic       busy;
    logic [2:0] act_state;
    logic [4:0] frames_left;

    logic [13:0] obs;
    logic [13:0] exp_v;
    int checks = 0;
    int errors = 0;

    assign obs = {act_state, frames_left, busy,
                  punch_start, kick_start, block_start, abort, hit_blocked};

    p2_action_sequencer dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .punch_req   (punch_req),
        .kick_req    (kick_req),
        .block_req   (block_req),
        .hit_in      (hit_in),
        .punch_start (punch_start),
        .kick_start  (kick_start),
        .block_start (block_start),
        .abort       (abort),
        .hit_blocked (hit_blocked),
        .busy        (busy),
        .act_state   (act_state),
        .frames_left (frames_left)
    );

    always #5 clk = ~clk;

    task automatic do_tick();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic pulse_hit();
        hit_in = 1'b1;
        @(posedge clk);
        #1 hit_in = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_punch();
        logic [2:0] s;
        logic [4:0] f;
        punch_req = 1'b1;
        do_tick();
        exp_v = {S_PUN, 5'd6, 1'b1, P_PUNCH};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL punch_accept got %b want %b", obs, exp_v);
        end
        @(posedge clk);
        #1;
        exp_v = {S_PUN, 5'd6, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL punch_pulse_width got %b want %b", obs, exp_v);
        end
        // Key stays held throughout: no repeat after returning to IDLE.
        for (int t = 1; t <= 11; t++) begin
            do_tick();
            if (t <= 5) begin
                s = S_PUN;  f = 5'(6 - t);
            end else if (t <= 9) begin
                s = S_COOL; f = 5'(10 - t);
            end else begin
                s = S_IDLE; f = 5'd0;
            end
            exp_v = {s, f, (s != S_IDLE), P_NONE};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL punch_seq t=%0d got %b want %b", t, obs, exp_v);
            end
        end
        punch_req = 1'b0;
        do_tick();
    endtask

    task automatic test_simultaneous();
        punch_req = 1'b1;
        kick_req  = 1'b1;
        do_tick();
        exp_v = {S_PUN, 5'd6, 1'b1, P_PUNCH};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL tie_punch_wins got %b want %b", obs, exp_v);
        end
        repeat (10) do_tick();
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL tie_idle_return got %b want %b", obs, exp_v);
        end
        do_tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL tie_kick_dropped got %b want %b", obs, exp_v);
        end
        punch_req = 1'b0;
        kick_req  = 1'b0;
        do_tick();
    endtask

    task automatic test_hit_abort();
        punch_req = 1'b1;
        do_tick();
        punch_req = 1'b0;
        do_tick();
        exp_v = {S_PUN, 5'd5, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hit_pre got %b want %b", obs, exp_v);
        end
        pulse_hit();
        exp_v = {S_PUN, 5'd5, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hit_pending_waits got %b want %b", obs, exp_v);
        end
        do_tick();
        exp_v = {S_STUN, 5'd10, 1'b1, P_ABORT};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hit_abort got %b want %b", obs, exp_v);
        end
        do_tick();
        pulse_hit();
        do_tick();
        exp_v = {S_STUN, 5'd8, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL stun_rehit got %b want %b", obs, exp_v);
        end
        repeat (8) do_tick();
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL stun_exit got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_block();
        block_req = 1'b1;
        do_tick();
        exp_v = {S_BLK, 5'd2, 1'b1, P_BLOCK};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_enter got %b want %b", obs, exp_v);
        end
        do_tick();
        do_tick();
        exp_v = {S_BLK, 5'd0, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_hold got %b want %b", obs, exp_v);
        end
        pulse_hit();
        do_tick();
        exp_v = {S_BLK, 5'd0, 1'b1, P_HB};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hit_blocked got %b want %b", obs, exp_v);
        end
        block_req = 1'b0;
        do_tick();
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_release got %b want %b", obs, exp_v);
        end
        block_req = 1'b1;
        do_tick();
        block_req = 1'b0;
        do_tick();
        exp_v = {S_BLK, 5'd1, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_min_hold got %b want %b", obs, exp_v);
        end
        do_tick();
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_min_exit got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_buffer();
        punch_req = 1'b1;
        do_tick();
        punch_req = 1'b0;
        do_tick();
        do_tick();
        kick_req = 1'b1;
        do_tick();
        exp_v = {S_PUN, 5'd3, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL buf_kick_during_punch got %b want %b", obs, exp_v);
        end
        repeat (6) do_tick();
        exp_v = {S_COOL, 5'd1, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL buf_cooldown_last got %b want %b", obs, exp_v);
        end
        do_tick();
`ifdef INPUT_BUFFER_EN
        exp_v = {S_KICK, 5'd8, 1'b1, P_KICK};
`else
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
`endif
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL buf_cooldown_exit got %b want %b", obs, exp_v);
        end
        do_tick();
`ifdef INPUT_BUFFER_EN
        exp_v = {S_KICK, 5'd7, 1'b1, P_NONE};
`else
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
`endif
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL buf_after_exit got %b want %b", obs, exp_v);
        end
        kick_req = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        kick_req = 1'b1;
        do_tick();
        exp_v = {S_KICK, 5'd8, 1'b1, P_KICK};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL kick_accept got %b want %b", obs, exp_v);
        end
        kick_req = 1'b0;
        do_tick();
        do_tick();
        exp_v = {S_KICK, 5'd6, 1'b1, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL kick_frame3 got %b want %b", obs, exp_v);
        end
        Reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_v = {S_IDLE, 5'd0, 1'b0, P_NONE};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_kick got %b want %b", obs, exp_v);
        end
        Reset_n = 1'b1;
        do_tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_after got %b want %b", obs, exp_v);
        end
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        punch_req  = 1'b0;
        kick_req   = 1'b0;
        block_req  = 1'b0;
        hit_in     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_punch();
        test_simultaneous();
        test_hit_abort();
        test_block();
        test_buffer();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
